muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 118 +++++++++++
 tb/tb_muldiv_unit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply-divide unit: 32-cycle unsigned shift-add MULTU and
// restoring DIVU, plus single-cycle MTHI/MTLO writes.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic        hisel,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        divzero
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q;
  logic        is_div_q;
  logic [31:0] opb_q;          // multiplicand (MULTU) or divisor (DIVU)
  logic [63:0] acc_q, acc_d;   // MULTU: {partial sum, multiplier}; DIVU: [31:0] dividend -> quotient
  logic [32:0] rem_q, rem_d;
  logic [31:0] hi_q, lo_q, hi_d, lo_d;
  logic        done_q, done_d, divzero_q, divzero_d;
  logic        accept, last;
  logic [32:0] sum, shifted;
  logic [33:0] diff;

  assign accept = (state_q == IDLE) && start;
  assign last   = (state_q == RUN) && (cnt_q == 6'd31);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && !op[1]) state_d = RUN;
      RUN:  if (last)             state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy      = (state_q == RUN);
    done_d    = last || (accept && op[1]);
    divzero_d = last && is_div_q && (opb_q == 32'd0);
    rdata     = hisel ? hi_q : lo_q;
  end

  assign done    = done_q;
  assign divzero = divzero_q;

  // One iteration step for each algorithm
  always_comb begin
    sum     = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    shifted = {rem_q[31:0], acc_q[31]};
    diff    = {1'b0, shifted} - {2'b00, opb_q};
    acc_d   = acc_q;
    rem_d   = rem_q;
    if (is_div_q) begin
      // Non-negative trial difference keeps the subtraction and sets the quotient bit
      rem_d = diff[33] ? shifted : diff[32:0];
      acc_d = {acc_q[63:32], acc_q[30:0], ~diff[33]};
    end else begin
      acc_d = {sum, acc_q[31:1]};
    end
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (accept && op == 2'b10) hi_d = srca;
    if (accept && op == 2'b11) lo_d = srca;
    if (last) begin
      hi_d = is_div_q ? rem_d[31:0] : acc_d[63:32];
      lo_d = acc_d[31:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= 6'd0;
      is_div_q  <= 1'b0;
      opb_q     <= 32'd0;
      acc_q     <= 64'd0;
      rem_q     <= 33'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
      if (accept && !op[1]) begin
        cnt_q    <= 6'd0;
        is_div_q <= op[0];
        opb_q    <= op[0] ? srcb : srca;
        acc_q    <= op[0] ? {32'd0, srca} : {32'd0, srcb};
        rem_q    <= 33'd0;
      end else if (state_q == RUN) begin
        cnt_q <= cnt_q + 6'd1;
        acc_q <= acc_d;
        rem_q <= rem_d;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus queues requests, a negedge monitor
// computes results with plain arithmetic and checks HI/LO, busy length, divzero.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start, hisel;
  logic [1:0]  op;
  logic [31:0] srca, srcb, rdata;
  logic        busy, done, divzero;

  typedef struct {logic [1:0] op; logic [31:0] a; logic [31:0] b;} req_t;
  req_t q[$];

  int   n_chk = 0, n_fail = 0;
  bit   end_req = 1'b0;

  localparam logic [1:0] MULTU = 2'b00, DIVU = 2'b01, MTHI = 2'b10, MTLO = 2'b11;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .hisel(hisel), .rdata(rdata), .busy(busy), .done(done), .divzero(divzero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    req_t r;
    int   guard = 0;
    while (busy && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    start = 1'b1; op = o; srca = a; srcb = b;
    r.op = o; r.a = a; r.b = b;
    q.push_back(r);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Stimulus
  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; op = 2'b00; srca = '0; srcb = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    issue(MULTU, 32'd7, 32'd6);
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(DIVU, 32'd100, 32'd7);
    issue(DIVU, 32'd5, 32'd0);

    // start while busy must be dropped
    issue(MULTU, 32'd3, 32'd4);
    repeat (9) @(posedge clk);
    #1 start = 1'b1; op = DIVU; srca = 32'd9; srcb = 32'd3;
    @(posedge clk); #1 start = 1'b0;

    // abort a running multiply with reset
    issue(MULTU, 32'd5, 32'd5);
    repeat (14) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    issue(MTHI, 32'hDEAD_BEEF, 32'd0);

    issue(MULTU, 32'd2, 32'd3);
    issue(DIVU, 32'd6, 32'd4);
    issue(MTLO, 32'h1234_5678, 32'd0);
    issue(MTHI, 32'hCAFE_F00D, 32'd0);

    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      issue(ro, ra, rb);
    end

    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    end_req = 1'b1;
  end

  // Monitor / scoreboard
  initial begin
    req_t        e;
    logic [31:0] cur_hi = '0, cur_lo = '0;
    logic [63:0] p;
    logic        exp_dz;
    int          busy_cnt = 0, cyc = 0;
    hisel = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc > 20000) begin
        n_fail++;
        $display("FAIL watchdog: got %0d cycles expected under 20000", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
      exp_dz = 1'b0;
      if (reset) begin
        q.delete();
        cur_hi = '0; cur_lo = '0; busy_cnt = 0;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
      end else begin
        if (busy) busy_cnt++;
        if (busy_cnt == 40) chk("busy_stuck", 64'(busy_cnt), 64'd32);
        if (done) begin
          n_chk++;
          if (q.size() == 0) begin
            n_fail++;
            $display("FAIL spurious_done: got done=1 expected no pending request");
          end else begin
            e = q.pop_front();
            case (e.op)
              MULTU: begin p = 64'(e.a) * 64'(e.b); cur_hi = p[63:32]; cur_lo = p[31:0]; end
              DIVU: begin
                if (e.b == 0) begin cur_hi = e.a; cur_lo = 32'hFFFF_FFFF; exp_dz = 1'b1; end
                else begin cur_hi = e.a % e.b; cur_lo = e.a / e.b; end
              end
              MTHI: cur_hi = e.a;
              default: cur_lo = e.a;
            endcase
            chk("busy_len", 64'(busy_cnt), e.op[1] ? 64'd0 : 64'd32);
          end
          busy_cnt = 0;
        end
      end
      chk("divzero", 64'(divzero), 64'(exp_dz));
      hisel = 1'b1; #1;
      chk("hi", 64'(rdata), 64'(cur_hi));
      hisel = 1'b0; #1;
      chk("lo", 64'(rdata), 64'(cur_lo));
      if (end_req) begin
        chk("drain", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
    end
  end

endmodule
